// File: rtl/thread_pkg.sv
// Shared thread-scheduling constants: thread count, id width,
// branch-mispredict field positions and penalty counter width.
package thread_pkg;

  localparam int unsigned NUM_THREADS    = 4;
  localparam int unsigned THREAD_ID_W    = 2;
  localparam int unsigned MISP_W         = 4;
  localparam int unsigned MISP_VALID_BIT = 3;
  localparam int unsigned MISP_TAKEN_BIT = 2;
  localparam int unsigned MISP_ID_MSB    = 1;
  localparam int unsigned MISP_ID_LSB    = 0;
  localparam int unsigned PENALTY_W      = 3;

  // rr_last reset value, chosen so thread 0 is searched first after reset
  localparam logic [THREAD_ID_W-1:0] RR_LAST_RST = 2'b11;

  // Extract the thread id field of a branch-mispredict word
  function automatic logic [THREAD_ID_W-1:0] misp_id(input logic [MISP_W-1:0] misp);
    return misp[MISP_ID_MSB:MISP_ID_LSB];
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way rotating-priority arbiter.
// Searches i_last+1, +2, +3, +4 (mod 4); the first requester wins.
// When only i_last requests, it wins again.
module rr_arbiter4
  import thread_pkg::*;
(
  input  logic [NUM_THREADS-1:0] i_request,
  input  logic [THREAD_ID_W-1:0] i_last,
  output logic [THREAD_ID_W-1:0] o_grant_c,
  output logic                   o_valid_c
);

  logic [THREAD_ID_W-1:0] w_idx;

  // Walk the order from farthest to nearest so the nearest requester is written last
  always_comb begin
    o_grant_c = i_last;
    o_valid_c = 1'b0;
    w_idx     = i_last;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      w_idx = i_last + THREAD_ID_W'(k);
      if (i_request[w_idx]) begin
        o_grant_c = w_idx;
        o_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Fetch thread scheduler: picks one of four threads per cycle with
// rotating priority, skipping disabled, queue-full and penalized threads.
// Optional feature macro: THREAD_SCHED_PENALTY_EN enables per-thread
// mispredict penalty counters and o_thread_blocked; otherwise the
// mispredict input is ignored and o_thread_blocked is constant 0.
module thread_scheduler
  import thread_pkg::*;
#(
  parameter int unsigned PENALTY_CYCLES = 3
)
(
  input  logic                   i_Clk,
  input  logic                   i_Reset_n,
  input  logic                   i_Stall,
  input  logic [NUM_THREADS-1:0] i_thread_enable,
  input  logic [NUM_THREADS-1:0] i_queue_full,
  input  logic [MISP_W-1:0]      i_branch_mispredict,
  output logic [THREAD_ID_W-1:0] o_thread_choice,
  output logic                   o_thread_valid,
  output logic [NUM_THREADS-1:0] o_thread_blocked
);

  logic [NUM_THREADS-1:0] w_eligible;
  logic [NUM_THREADS-1:0] w_penalty_busy;
  logic [NUM_THREADS-1:0] w_blocked_nxt;
  logic [THREAD_ID_W-1:0] r_rr_last;
  logic [THREAD_ID_W-1:0] w_grant;
  logic                   w_grant_valid;
  logic                   w_unused_taken;

  // The taken bit is consumed by the fetch unit, not by scheduling
  assign w_unused_taken = i_branch_mispredict[MISP_TAKEN_BIT];

`ifdef THREAD_SCHED_PENALTY_EN
  logic [PENALTY_W-1:0]   r_penalty     [NUM_THREADS];
  logic [PENALTY_W-1:0]   w_penalty_nxt [NUM_THREADS];
  logic                   w_misp_valid;
  logic [THREAD_ID_W-1:0] w_misp_id;

  assign w_misp_valid = i_branch_mispredict[MISP_VALID_BIT];
  assign w_misp_id    = misp_id(i_branch_mispredict);

  // Penalty next state: mispredict reload wins over the saturating decrement
  always_comb begin
    for (int n = 0; n < NUM_THREADS; n++) begin
      w_penalty_nxt[n] = r_penalty[n];
      if (w_misp_valid && (w_misp_id == THREAD_ID_W'(n))) begin
        w_penalty_nxt[n] = PENALTY_W'(PENALTY_CYCLES);
      end else if (r_penalty[n] != '0) begin
        w_penalty_nxt[n] = r_penalty[n] - PENALTY_W'(1);
      end
      w_penalty_busy[n] = (r_penalty[n] != '0);
      w_blocked_nxt[n]  = (w_penalty_nxt[n] != '0);
    end
  end

  // Penalty counters run regardless of stall
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int n = 0; n < NUM_THREADS; n++) begin
        r_penalty[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_THREADS; n++) begin
        r_penalty[n] <= w_penalty_nxt[n];
      end
    end
  end
`else
  logic w_unused_misp;

  assign w_penalty_busy = '0;
  assign w_blocked_nxt  = '0;
  assign w_unused_misp  = ^{i_branch_mispredict[MISP_VALID_BIT],
                            misp_id(i_branch_mispredict),
                            PENALTY_W'(PENALTY_CYCLES)};
`endif

  // A thread may be fetched only if enabled, not full and not penalized
  assign w_eligible = i_thread_enable & ~i_queue_full & ~w_penalty_busy;

  rr_arbiter4 u_rr_arbiter4 (
    .i_request (w_eligible),
    .i_last    (r_rr_last),
    .o_grant_c (w_grant),
    .o_valid_c (w_grant_valid)
  );

  // Grant register: update on non-stalled edges, hold choice when nothing is eligible
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_thread_choice <= '0;
      o_thread_valid  <= 1'b0;
      r_rr_last       <= RR_LAST_RST;
    end else if (!i_Stall) begin
      if (w_grant_valid) begin
        o_thread_choice <= w_grant;
        r_rr_last       <= w_grant;
        o_thread_valid  <= 1'b1;
      end else begin
        o_thread_valid  <= 1'b0;
      end
    end
  end

  // Blocked flags track the counters they will hold after this edge
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_thread_blocked <= '0;
    end else begin
      o_thread_blocked <= w_blocked_nxt;
    end
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// Scoreboard bench for thread_scheduler: directed per-cycle vectors push
// hand-computed expectations; a monitor pops and compares after each edge.
module tb_thread_scheduler;

  typedef struct packed {
    logic [1:0] choice;
    logic       valid;
    logic [3:0] blocked;
  } exp_t;

  logic       i_Clk = 1'b0;
  logic       i_Reset_n = 1'b0;
  logic       i_Stall = 1'b0;
  logic [3:0] i_thread_enable = 4'b0000;
  logic [3:0] i_queue_full = 4'b0000;
  logic [3:0] i_branch_mispredict = 4'b0000;
  logic [1:0] o_thread_choice;
  logic       o_thread_valid;
  logic [3:0] o_thread_blocked;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_idx = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  thread_scheduler #(.PENALTY_CYCLES(3)) dut (
    .i_Clk               (i_Clk),
    .i_Reset_n           (i_Reset_n),
    .i_Stall             (i_Stall),
    .i_thread_enable     (i_thread_enable),
    .i_queue_full        (i_queue_full),
    .i_branch_mispredict (i_branch_mispredict),
    .o_thread_choice     (o_thread_choice),
    .o_thread_valid      (o_thread_valid),
    .o_thread_blocked    (o_thread_blocked)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic step(input logic s, input logic [3:0] en, input logic [3:0] fl,
                      input logic [3:0] mp, input logic [1:0] c, input logic v,
                      input logic [3:0] b);
    exp_t e;
    @(negedge i_Clk);
    i_Stall             = s;
    i_thread_enable     = en;
    i_queue_full        = fl;
    i_branch_mispredict = mp;
    e.choice  = c;
    e.valid   = v;
    e.blocked = b;
    exp_q.push_back(e);
  endtask

  // Monitor: compare registered outputs just after each active edge
  always @(posedge i_Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check($sformatf("choice[%0d]", mon_idx), int'(o_thread_choice), int'(mon_e.choice));
      check($sformatf("valid[%0d]", mon_idx), int'(o_thread_valid), int'(mon_e.valid));
      check($sformatf("blocked[%0d]", mon_idx), int'(o_thread_blocked), int'(mon_e.blocked));
      mon_idx++;
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge i_Clk);
    check("rst_choice", int'(o_thread_choice), 0);
    check("rst_valid", int'(o_thread_valid), 0);
    check("rst_blocked", int'(o_thread_blocked), 0);
    i_Reset_n = 1'b1;

    // Full rotation from reset: 0,1,2,3,0
    step(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1, 4'b0000);
    step(0, 4'b1111, 4'b0000, 4'b0000, 2'd1, 1, 4'b0000);
    step(0, 4'b1111, 4'b0000, 4'b0000, 2'd2, 1, 4'b0000);
    step(0, 4'b1111, 4'b0000, 4'b0000, 2'd3, 1, 4'b0000);
    step(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1, 4'b0000);
    // Sparse enable alternates 1,3; single thread repeats
    step(0, 4'b1010, 4'b0000, 4'b0000, 2'd1, 1, 4'b0000);
    step(0, 4'b1010, 4'b0000, 4'b0000, 2'd3, 1, 4'b0000);
    step(0, 4'b1010, 4'b0000, 4'b0000, 2'd1, 1, 4'b0000);
    step(0, 4'b1010, 4'b0000, 4'b0000, 2'd3, 1, 4'b0000);
    step(0, 4'b0100, 4'b0000, 4'b0000, 2'd2, 1, 4'b0000);
    step(0, 4'b0100, 4'b0000, 4'b0000, 2'd2, 1, 4'b0000);
    step(0, 4'b0100, 4'b0000, 4'b0000, 2'd2, 1, 4'b0000);
    // Stall freezes choice/valid, resume from rr_last+1
    step(0, 4'b1111, 4'b0000, 4'b0000, 2'd3, 1, 4'b0000);
    step(1, 4'b1111, 4'b0000, 4'b0000, 2'd3, 1, 4'b0000);
    step(1, 4'b1111, 4'b0000, 4'b0000, 2'd3, 1, 4'b0000);
    step(1, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1, 4'b0000);
    step(1, 4'b1111, 4'b0000, 4'b0000, 2'd3, 1, 4'b0000);
    step(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1, 4'b0000);
    step(0, 4'b1111, 4'b0000, 4'b0000, 2'd1, 1, 4'b0000);
    // Current choice deasserts enable and is not re-granted
    step(0, 4'b0010, 4'b0000, 4'b0000, 2'd1, 1, 4'b0000);
    step(0, 4'b0001, 4'b0000, 4'b0000, 2'd0, 1, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 4'b0000);
    step(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, 4'b0000);
    // All queues full: invalid, choice holds; freeing thread 2 grants it
    step(0, 4'b1111, 4'b1111, 4'b0000, 2'd0, 0, 4'b0000);
    step(0, 4'b1111, 4'b1011, 4'b0000, 2'd2, 1, 4'b0000);
    step(0, 4'b1111, 4'b0000, 4'b0000, 2'd3, 1, 4'b0000);
    step(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1, 4'b0000);

`ifdef THREAD_SCHED_PENALTY_EN
    // Mispredict on thread 1: granted this edge, then skipped for 3 cycles
    step(0, 4'b0011, 4'b0000, 4'b1001, 2'd1, 1, 4'b0010);
    step(0, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1, 4'b0010);
    step(0, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1, 4'b0010);
    step(0, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1, 4'b0000);
    step(0, 4'b0011, 4'b0000, 4'b0000, 2'd1, 1, 4'b0000);
    // Back-to-back mispredicts extend the window from the second one
    step(0, 4'b0011, 4'b0000, 4'b1101, 2'd0, 1, 4'b0010);
    step(0, 4'b0011, 4'b0000, 4'b1001, 2'd0, 1, 4'b0010);
    step(0, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1, 4'b0010);
    step(0, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1, 4'b0010);
    step(0, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1, 4'b0000);
    step(0, 4'b0011, 4'b0000, 4'b0000, 2'd1, 1, 4'b0000);
    // Penalty loads and counts down through a stall
    step(1, 4'b0011, 4'b0000, 4'b1000, 2'd1, 1, 4'b0001);
    step(1, 4'b0011, 4'b0000, 4'b0000, 2'd1, 1, 4'b0001);
    step(1, 4'b0011, 4'b0000, 4'b0000, 2'd1, 1, 4'b0001);
    step(0, 4'b0011, 4'b0000, 4'b0000, 2'd1, 1, 4'b0000);
    step(0, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1, 4'b0000);
    // Penalize thread 2 just before the mid-operation reset
    step(0, 4'b0011, 4'b0000, 4'b1010, 2'd1, 1, 4'b0100);
`else
    // Mispredicts are ignored: plain alternation between threads 0 and 1
    step(0, 4'b0011, 4'b0000, 4'b1001, 2'd1, 1, 4'b0000);
    step(0, 4'b0011, 4'b0000, 4'b1000, 2'd0, 1, 4'b0000);
    step(0, 4'b0011, 4'b0000, 4'b1101, 2'd1, 1, 4'b0000);
    step(0, 4'b0011, 4'b0000, 4'b0000, 2'd0, 1, 4'b0000);
    step(0, 4'b0011, 4'b0000, 4'b0000, 2'd1, 1, 4'b0000);
`endif

    // Asynchronous reset between edges: outputs clear immediately
    @(posedge i_Clk);
    #3;
    i_Reset_n = 1'b0;
    #1;
    check("async_rst_choice", int'(o_thread_choice), 0);
    check("async_rst_valid", int'(o_thread_valid), 0);
    check("async_rst_blocked", int'(o_thread_blocked), 0);
    i_thread_enable     = 4'b0000;
    i_branch_mispredict = 4'b0000;
    i_Stall             = 1'b0;
    @(negedge i_Clk);
    i_Reset_n = 1'b1;
    // rr_last back at 3 and penalties cleared
    step(0, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1, 4'b0000);
    step(0, 4'b0100, 4'b0000, 4'b0000, 2'd2, 1, 4'b0000);
    step(0, 4'b0100, 4'b0000, 4'b0000, 2'd2, 1, 4'b0000);

    // Let the monitor drain the queue within a bounded number of cycles
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge i_Clk);
    end
    #2;
    check("queue_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
